// File: rtl/bus_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter_pkg
// Purpose : Definitions shared by the two-core gpiomem arbiter, its mux and
//           the bus interface. It holds the arbiter state encoding, the
//           read/write direction values and the default bus widths.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package bus_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN0    = 2'd1,
        OWN1    = 2'd2,
        HANDOFF = 2'd3
    } arb_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Default widths of the gpiomem port, also used by the cores and gpiomem.
    localparam int BUS_ADDR_W = 9;
    localparam int BUS_DATA_W = 8;

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter_if
// Purpose : Groups the signals that pass between core0, core1, the arbiter
//           and gpiomem into one bundle.
// Ports   : core0_* / core1_* : request, grant, address, data_in, data_out, rw
//           RAM_*             : address, data_in, data_out toward gpiomem
//           rw                : gpiomem direction (1 = write)
//           bus_busy, owner   : arbiter status
// Modports: master - the core/memory side, which drives the requests and the
//                    read data
//           slave  - the arbiter, which drives the grants and the memory port
// ---------------------------------------------------------------------------
interface bus_rr_arbiter_if
    import bus_rr_arbiter_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
);
    logic              core0_request;
    logic              core0_grant;
    logic [ADDR_W-1:0] core0_address;
    logic [DATA_W-1:0] core0_data_in;
    logic [DATA_W-1:0] core0_data_out;
    logic              core0_rw;

    logic              core1_request;
    logic              core1_grant;
    logic [ADDR_W-1:0] core1_address;
    logic [DATA_W-1:0] core1_data_in;
    logic [DATA_W-1:0] core1_data_out;
    logic              core1_rw;

    logic [ADDR_W-1:0] RAM_address;
    logic [DATA_W-1:0] RAM_data_in;
    logic [DATA_W-1:0] RAM_data_out;
    logic              rw;

    logic              bus_busy;
    logic              owner;

    modport master (
        output core0_request, core0_address, core0_data_in, core0_rw,
        output core1_request, core1_address, core1_data_in, core1_rw,
        output RAM_data_out,
        input  core0_grant, core0_data_out, core1_grant, core1_data_out,
        input  RAM_address, RAM_data_in, rw, bus_busy, owner
    );

    modport slave (
        input  core0_request, core0_address, core0_data_in, core0_rw,
        input  core1_request, core1_address, core1_data_in, core1_rw,
        input  RAM_data_out,
        output core0_grant, core0_data_out, core1_grant, core1_data_out,
        output RAM_address, RAM_data_in, rw, bus_busy, owner
    );

endinterface

// File: rtl/bus_rr_arbiter_mux.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter_mux
// Purpose : Purely combinational datapath of the arbiter. It forwards the
//           granted core's address, write data and direction to gpiomem, and
//           it steers the gpiomem read data back to the granted core only.
// Ports   : grant0/grant1       - registered grants from the arbiter FSM
//           write_enable        - low forces rw to read (used while in reset)
//           core0_*/core1_*     - per-core address, data_in, rw, data_out
//           ram_*/rw            - gpiomem side
// ---------------------------------------------------------------------------
module bus_rr_arbiter_mux
    import bus_rr_arbiter_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              grant0,
    input  logic              grant1,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] core0_address,
    input  logic [DATA_W-1:0] core0_data_in,
    input  logic              core0_rw,
    output logic [DATA_W-1:0] core0_data_out,
    input  logic [ADDR_W-1:0] core1_address,
    input  logic [DATA_W-1:0] core1_data_in,
    input  logic              core1_rw,
    output logic [DATA_W-1:0] core1_data_out,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              rw
);

    // With no owner the memory port idles at zero in read mode, so a core
    // that asserts rw without holding a grant can never cause a write.
    always_comb begin
        ram_address    = '0;
        ram_data_in    = '0;
        rw             = RW_READ;
        core0_data_out = '0;
        core1_data_out = '0;
        if (grant0) begin
            ram_address    = core0_address;
            ram_data_in    = core0_data_in;
            rw             = core0_rw & write_enable;
            core0_data_out = ram_data_out;
        end else if (grant1) begin
            ram_address    = core1_address;
            ram_data_in    = core1_data_in;
            rw             = core1_rw & write_enable;
            core1_data_out = ram_data_out;
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
// Purpose : Two-master round-robin arbiter between core0/core1 and the
//           single-port gpiomem. It gives grants with a bounded tenure and
//           inserts one dead cycle on every change of ownership.
// Ports   : clk   - core clock, rising edge
//           reset - synchronous, active low
//           bus   - bus_rr_arbiter_if.slave (core request/grant/data, gpiomem
//                   port, bus_busy, owner)
// Params  : MAX_HOLD - maximum consecutive granted cycles while the other core
//                      waits (0 = unlimited)
//           ADDR_W / DATA_W - bus widths
// ---------------------------------------------------------------------------
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W
) (
    input  logic            clk,
    input  logic            reset,
    bus_rr_arbiter_if.slave bus
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam bit HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_SAT  = '1;

    arb_state_e       state;
    arb_state_e       next_state;
    logic             last_owner;
    logic [CNT_W-1:0] hold_cnt;
    logic             grant0;
    logic             grant1;
    logic             req0;
    logic             req1;

    assign req0 = bus.core0_request;
    assign req1 = bus.core1_request;

    // Next-state decision. In OWNx a dropped request has priority over a
    // forced release. A forced release happens on the owner's last allowed
    // cycle, and only when the other core is actually waiting.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    next_state = last_owner ? OWN0 : OWN1;
                else if (req0)
                    next_state = OWN0;
                else if (req1)
                    next_state = OWN1;
            end
            OWN0: begin
                if (!req0)
                    next_state = req1 ? HANDOFF : IDLE;
                else if (HOLD_LIMITED && req1 && hold_cnt == HOLD_LAST)
                    next_state = HANDOFF;
            end
            OWN1: begin
                if (!req1)
                    next_state = req0 ? HANDOFF : IDLE;
                else if (HOLD_LIMITED && req0 && hold_cnt == HOLD_LAST)
                    next_state = HANDOFF;
            end
            HANDOFF: begin
                if (last_owner ? req0 : req1)
                    next_state = last_owner ? OWN0 : OWN1;
                else if (last_owner ? req1 : req0)
                    next_state = last_owner ? OWN1 : OWN0;
                else
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The grants are registered from the next state, so they always match
    // the state register. The hold counter restarts on every state change and
    // counts up while the same core stays in ownership.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
            grant0     <= 1'b0;
            grant1     <= 1'b0;
        end else begin
            state  <= next_state;
            grant0 <= (next_state == OWN0);
            grant1 <= (next_state == OWN1);
            if (next_state == OWN0)
                last_owner <= 1'b0;
            else if (next_state == OWN1)
                last_owner <= 1'b1;
            if (next_state != state)
                hold_cnt <= '0;
            else if ((state == OWN0 || state == OWN1) && hold_cnt != HOLD_SAT)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign bus.core0_grant = grant0;
    assign bus.core1_grant = grant1;
    assign bus.bus_busy    = grant0 | grant1;
    assign bus.owner       = last_owner;

    // write_enable is tied to reset, so no write reaches gpiomem in a cycle
    // where reset is asserted, even before the grant drops at the edge.
    bus_rr_arbiter_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .grant0         (grant0),
        .grant1         (grant1),
        .write_enable   (reset),
        .core0_address  (bus.core0_address),
        .core0_data_in  (bus.core0_data_in),
        .core0_rw       (bus.core0_rw),
        .core0_data_out (bus.core0_data_out),
        .core1_address  (bus.core1_address),
        .core1_data_in  (bus.core1_data_in),
        .core1_rw       (bus.core1_rw),
        .core1_data_out (bus.core1_data_out),
        .ram_address    (bus.RAM_address),
        .ram_data_in    (bus.RAM_data_in),
        .ram_data_out   (bus.RAM_data_out),
        .rw             (bus.rw)
    );

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_rr_arbiter
// Purpose : Directed bench for bus_rr_arbiter with MAX_HOLD = 4. Each task
//           drives one scenario and compares the outputs with hand-derived
//           values.
// ---------------------------------------------------------------------------
module tb_bus_rr_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    bus_rr_arbiter_if #(.ADDR_W(9), .DATA_W(8)) bus ();

    bus_rr_arbiter #(
        .MAX_HOLD (4),
        .ADDR_W   (9),
        .DATA_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after a falling edge and outputs are sampled at
    // falling edges, well away from the active rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.core0_request = 1'b0;
        bus.core0_address = '0;
        bus.core0_data_in = '0;
        bus.core0_rw      = 1'b0;
        bus.core1_request = 1'b0;
        bus.core1_address = '0;
        bus.core1_data_in = '0;
        bus.core1_rw      = 1'b0;
        bus.RAM_data_out  = '0;
    endtask

    // Reset held for two cycles while core0 requests a write. No grant and
    // no write may appear. After release core0 is granted one edge later.
    task automatic test_reset();
        reset = 1'b0;
        bus.core0_request = 1'b1;
        bus.core0_rw      = 1'b1;
        bus.core0_address = 9'h1FF;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({bus.core0_grant, bus.core1_grant, bus.rw, bus.bus_busy, bus.owner} !== 5'b00001) begin
                bad++;
                $display("[TB] FAIL reset_state cyc=%0d got g0,g1,rw,busy,owner=%b%b%b%b%b want 00001",
                         i, bus.core0_grant, bus.core1_grant, bus.rw, bus.bus_busy, bus.owner);
            end
            total++;
            if ({bus.RAM_address, bus.RAM_data_in, bus.core0_data_out, bus.core1_data_out} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_datapath cyc=%0d got addr=%h din=%h d0=%h d1=%h want all 0",
                         i, bus.RAM_address, bus.RAM_data_in, bus.core0_data_out, bus.core1_data_out);
            end
        end
        reset = 1'b1;
        tick();
        total++;
        if ({bus.core0_grant, bus.core1_grant, bus.rw, bus.owner} !== 4'b1010) begin
            bad++;
            $display("[TB] FAIL reset_release got g0,g1,rw,owner=%b%b%b%b want 1010",
                     bus.core0_grant, bus.core1_grant, bus.rw, bus.owner);
        end
        clear_inputs();
        tick();
    endtask

    // A tie straight after reset goes to core0. When core0 drops its request
    // there is one dead cycle, and then core1 is granted.
    task automatic test_tie_and_handoff();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.core0_request = 1'b1;
        bus.core1_request = 1'b1;
        bus.core0_rw      = 1'b1;
        bus.core1_rw      = 1'b1;
        tick();
        total++;
        if ({bus.core0_grant, bus.core1_grant} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL tie_first got g0,g1=%b%b want 10", bus.core0_grant, bus.core1_grant);
        end
        bus.core0_request = 1'b0;
        tick();
        total++;
        if ({bus.core0_grant, bus.core1_grant, bus.rw, bus.bus_busy} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL handoff_gap got g0,g1,rw,busy=%b%b%b%b want 0000",
                     bus.core0_grant, bus.core1_grant, bus.rw, bus.bus_busy);
        end
        tick();
        total++;
        if ({bus.core0_grant, bus.core1_grant, bus.owner} !== 3'b011) begin
            bad++;
            $display("[TB] FAIL handoff_next got g0,g1,owner=%b%b%b want 011",
                     bus.core0_grant, bus.core1_grant, bus.owner);
        end
        clear_inputs();
        tick();
    endtask

    // Both cores request continuously. Each owner keeps the bus for exactly
    // four cycles, and every switch has one gap cycle in which rw is 0.
    task automatic test_rotation();
        logic exp0;
        logic exp1;
        int   phase;
        bus.core0_request = 1'b1;
        bus.core1_request = 1'b1;
        bus.core0_rw      = 1'b1;
        bus.core1_rw      = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            phase = k % 10;
            exp0  = (phase < 4);
            exp1  = (phase >= 5) && (phase < 9);
            total++;
            if ({bus.core0_grant, bus.core1_grant, bus.rw} !== {exp0, exp1, exp0 | exp1}) begin
                bad++;
                $display("[TB] FAIL rotation cyc=%0d got g0,g1,rw=%b%b%b want %b%b%b",
                         k, bus.core0_grant, bus.core1_grant, bus.rw, exp0, exp1, exp0 | exp1);
            end
        end
        clear_inputs();
        tick();
    endtask

    // When core1 is the only requester there is no forced release: it keeps
    // the grant for all 40 cycles.
    task automatic test_single_no_gap();
        bus.core1_request = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if ({bus.core0_grant, bus.core1_grant} !== 2'b01) begin
                bad++;
                $display("[TB] FAIL single_hold cyc=%0d got g0,g1=%b%b want 01",
                         k, bus.core0_grant, bus.core1_grant);
            end
        end
        clear_inputs();
        tick();
    endtask

    // core0 writes while core1 drives rw=1 on a different address. Only
    // core0's transfer may reach memory, and read data goes only to core0.
    task automatic test_write_mux();
        bus.core0_request = 1'b1;
        bus.core0_rw      = 1'b1;
        bus.core0_address = 9'h105;
        bus.core0_data_in = 8'hA5;
        bus.core1_request = 1'b1;
        bus.core1_rw      = 1'b1;
        bus.core1_address = 9'h010;
        bus.core1_data_in = 8'h77;
        bus.RAM_data_out  = 8'h5A;
        tick();
        total++;
        if ({bus.core0_grant, bus.core1_grant} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL write_grant got g0,g1=%b%b want 10", bus.core0_grant, bus.core1_grant);
        end
        total++;
        if ({bus.RAM_address, bus.RAM_data_in, bus.rw} !== {9'h105, 8'hA5, 1'b1}) begin
            bad++;
            $display("[TB] FAIL write_port got addr=%h din=%h rw=%b want 105 a5 1",
                     bus.RAM_address, bus.RAM_data_in, bus.rw);
        end
        total++;
        if ({bus.core0_data_out, bus.core1_data_out} !== {8'h5A, 8'h00}) begin
            bad++;
            $display("[TB] FAIL write_rdata got d0=%h d1=%h want 5a 00",
                     bus.core0_data_out, bus.core1_data_out);
        end
        clear_inputs();
        tick();
    endtask

    // core1 reads 0x3C while core0 stays idle. After that, reset is asserted
    // mid-tenure: rw is blocked at once, and the grant drops at that edge.
    task automatic test_read_and_reset();
        bus.core1_request = 1'b1;
        bus.core1_rw      = 1'b0;
        bus.core1_address = 9'h0EE;
        bus.core0_rw      = 1'b1;
        bus.core0_address = 9'h033;
        bus.RAM_data_out  = 8'h3C;
        tick();
        total++;
        if ({bus.core1_grant, bus.owner, bus.rw, bus.RAM_address} !== {1'b1, 1'b1, 1'b0, 9'h0EE}) begin
            bad++;
            $display("[TB] FAIL read_port got g1=%b owner=%b rw=%b addr=%h want 1 1 0 0ee",
                     bus.core1_grant, bus.owner, bus.rw, bus.RAM_address);
        end
        total++;
        if ({bus.core0_data_out, bus.core1_data_out} !== {8'h00, 8'h3C}) begin
            bad++;
            $display("[TB] FAIL read_rdata got d0=%h d1=%h want 00 3c",
                     bus.core0_data_out, bus.core1_data_out);
        end
        bus.core1_rw = 1'b1;
        reset        = 1'b0;
        #1;
        total++;
        if ({bus.core1_grant, bus.rw} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL reset_cycle_write got g1,rw=%b%b want 10", bus.core1_grant, bus.rw);
        end
        tick();
        total++;
        if ({bus.core0_grant, bus.core1_grant, bus.bus_busy, bus.owner} !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL reset_mid_tenure got g0,g1,busy,owner=%b%b%b%b want 0001",
                     bus.core0_grant, bus.core1_grant, bus.bus_busy, bus.owner);
        end
        reset = 1'b1;
        clear_inputs();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_tie_and_handoff();
        test_rotation();
        test_single_no_gap();
        test_write_mux();
        test_read_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
